// File: rtl/axis_uart_frame_parser.sv
// Byte-stream frame parser: SOF, LEN, payload, XOR checksum. The payload is forwarded as an
// AXI-stream packet, and every started packet is closed with tlast, including on an abort.
module axis_uart_frame_parser #(
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       rx_err_pulse,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);
  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    ERR_CSUM = 2'b01;
  localparam logic [1:0]    ERR_TMO  = 2'b10;
  localparam logic [1:0]    ERR_LINE = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_PAYLOAD, ST_CSUM} state_t;
  state_t state, state_nxt;

  logic [7:0]    cnt, csum;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    out_data;
  logic          out_last, out_user, out_full, out_hold;
  logic          got_payload, term_pending;
  logic          s_ready, accept, pop, in_frame, tmo_hit, abort;
  logic [1:0]    abort_code;

  assign m_axis_tvalid = out_full && !out_hold;
  assign m_axis_tdata  = out_data;
  assign m_axis_tlast  = out_last;
  assign m_axis_tuser  = out_user;
  assign s_axis_tready = s_ready && !areset;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign in_frame      = (state != ST_IDLE);
  assign tmo_hit       = (tmo_cnt == TMO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every variable gets a default first, so no path through this block can infer a latch.
  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    abort      = 1'b0;
    abort_code = ERR_LINE;
    if (!term_pending) begin
      if (state == ST_PAYLOAD) s_ready = !out_full || pop;
      else                     s_ready = 1'b1;
    end
    accept = s_axis_tvalid && s_ready;
    // A line error beats a byte accepted in the same cycle; an accepted byte beats the timeout.
    if (in_frame && rx_err_pulse) begin
      abort      = 1'b1;
      abort_code = ERR_LINE;
    end else if (in_frame && tmo_hit && !accept) begin
      abort      = 1'b1;
      abort_code = ERR_TMO;
    end
    if (abort) begin
      state_nxt = ST_IDLE;
    end else if (accept) begin
      unique case (state)
        ST_IDLE:    if (s_axis_tdata == SOF_BYTE) state_nxt = ST_LEN;
        ST_LEN:     state_nxt = (s_axis_tdata == 8'd0) ? ST_CSUM : ST_PAYLOAD;
        ST_PAYLOAD: if (cnt == 8'd1) state_nxt = ST_CSUM;
        ST_CSUM:    state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt          <= '0;
      csum         <= '0;
      tmo_cnt      <= '0;
      out_data     <= '0;
      out_last     <= 1'b0;
      out_user     <= 1'b0;
      out_full     <= 1'b0;
      out_hold     <= 1'b0;
      got_payload  <= 1'b0;
      term_pending <= 1'b0;
      frame_ok     <= 1'b0;
      frame_err    <= 1'b0;
      err_code     <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (!in_frame || accept || abort)   tmo_cnt <= '0;
      else if (!s_axis_tvalid)            tmo_cnt <= tmo_cnt + TW'(1);

      if (pop) begin
        out_full     <= 1'b0;
        term_pending <= 1'b0;
      end

      if (abort) begin
        frame_err   <= 1'b1;
        err_code    <= abort_code;
        got_payload <= 1'b0;
        if (got_payload) begin
          // Close the open packet: retag the resident byte, or inject an empty bad beat.
          term_pending <= 1'b1;
          out_last     <= 1'b1;
          out_user     <= 1'b1;
          out_hold     <= 1'b0;
          if (!(out_full && !pop)) begin
            out_data <= 8'h00;
            out_full <= 1'b1;
          end
        end
      end else if (accept) begin
        unique case (state)
          ST_IDLE: begin
            if (s_axis_tdata == SOF_BYTE) begin
              csum        <= '0;
              got_payload <= 1'b0;
            end
          end
          ST_LEN: begin
            cnt  <= s_axis_tdata;
            csum <= s_axis_tdata;
          end
          ST_PAYLOAD: begin
            out_data    <= s_axis_tdata;
            out_last    <= 1'b0;
            out_user    <= 1'b0;
            out_full    <= 1'b1;
            out_hold    <= (cnt == 8'd1);
            csum        <= csum ^ s_axis_tdata;
            cnt         <= cnt - 8'd1;
            got_payload <= 1'b1;
          end
          ST_CSUM: begin
            if (out_hold) begin
              out_hold <= 1'b0;
              out_last <= 1'b1;
              out_user <= (s_axis_tdata != csum);
            end
            if (s_axis_tdata == csum) begin
              frame_ok <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CSUM;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axis_uart_frame_parser.sv
// Directed bench for axis_uart_frame_parser: good/bad frames, backpressure, timeout,
// line error and mid-frame reset, with hand-computed expectations.
module tb_axis_uart_frame_parser;
  localparam int TMO = 50;

  logic       aclk = 1'b0;
  logic       areset;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid, s_axis_tready, rx_err_pulse;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic       frame_ok, frame_err;
  logic [1:0] err_code;

  // {last, user, data}
  logic [9:0] beats[$];
  int ok_cnt = 0, err_cnt = 0;
  int n_cmp = 0, n_err = 0;
  int rd = 0;

  always #5 aclk = ~aclk;

  axis_uart_frame_parser #(.SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .rx_err_pulse  (rx_err_pulse),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .err_code      (err_code)
  );

  // Monitor samples on the falling edge, half a cycle away from the active edge.
  always @(negedge aclk) begin
    if (!areset) begin
      if (m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
      if (frame_ok)  ok_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [7:0] d, input logic l, input logic u);
    logic [9:0] got;
    got = 'x;
    if (rd < beats.size()) begin
      got = beats[rd];
      rd++;
    end
    check(tag, {22'd0, got}, {22'd0, l, u, d});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axis_tready && n < 200) begin
      n++;
      @(negedge aclk);
    end
    check("s_accept", {31'd0, s_axis_tready}, 32'd1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  initial begin
    int ok0, err0, n;
    areset = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0; rx_err_pulse = 1'b0; m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_m_tlast",  {31'd0, m_axis_tlast},  32'd0);
    check("rst_frame",    {30'd0, frame_ok, frame_err}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check("idle_s_tready", {31'd0, s_axis_tready}, 32'd1);
    @(posedge aclk); #1;

    // Test 1: good frame, csum 03^11^22^33 = 03
    ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    check("t1_lat_valid", {31'd0, m_axis_tvalid}, 32'd1);
    check("t1_lat_data",  {24'd0, m_axis_tdata}, 32'h11);
    send_byte(8'h22); send_byte(8'h33);
    check("t1_held", {31'd0, m_axis_tvalid}, 32'd0);
    send_byte(8'h03);
    check("t1_last_beat", {29'd0, m_axis_tvalid, m_axis_tlast, m_axis_tuser}, 32'b110);
    check("t1_last_data", {24'd0, m_axis_tdata}, 32'h33);
    check("t1_ok_pulse",  {31'd0, frame_ok}, 32'd1);
    idle(3);
    check_beat("t1_b0", 8'h11, 1'b0, 1'b0);
    check_beat("t1_b1", 8'h22, 1'b0, 1'b0);
    check_beat("t1_b2", 8'h33, 1'b1, 1'b0);
    check("t1_nbeats", beats.size(), rd);
    check("t1_ok",  ok_cnt - ok0, 1);
    check("t1_err", err_cnt - err0, 0);
    check("t1_code", {30'd0, err_code}, 32'd0);

    // Test 2: checksum mismatch (04 vs 03)
    ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h04);
    idle(3);
    check_beat("t2_b0", 8'h11, 1'b0, 1'b0);
    check_beat("t2_b1", 8'h22, 1'b0, 1'b0);
    check_beat("t2_b2", 8'h33, 1'b1, 1'b1);
    check("t2_nbeats", beats.size(), rd);
    check("t2_ok",  ok_cnt - ok0, 0);
    check("t2_err", err_cnt - err0, 1);
    check("t2_code", {30'd0, err_code}, 32'd1);

    // Test 3: junk bytes dropped, then an empty frame (csum = LEN = 00)
    ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    idle(3);
    check("t3_nbeats", beats.size(), rd);
    check("t3_ok",  ok_cnt - ok0, 1);
    check("t3_err", err_cnt - err0, 0);

    // Test 4: backpressure; checksum byte 04 differs from 04^01^02^03^04 = 00
    ok0 = ok_cnt; err0 = err_cnt;
    m_axis_tready = 1'b0;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    s_axis_tdata = 8'h02; s_axis_tvalid = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge aclk);
      if (s_axis_tready) n++;
    end
    check("t4_stall_ready", n, 0);
    check("t4_stall_data", {23'd0, m_axis_tvalid, m_axis_tdata}, {23'd0, 1'b1, 8'h01});
    @(posedge aclk); #1;
    m_axis_tready = 1'b1;
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h04);
    idle(3);
    check_beat("t4_b0", 8'h01, 1'b0, 1'b0);
    check_beat("t4_b1", 8'h02, 1'b0, 1'b0);
    check_beat("t4_b2", 8'h03, 1'b0, 1'b0);
    check_beat("t4_b3", 8'h04, 1'b1, 1'b1);
    check("t4_nbeats", beats.size(), rd);
    check("t4_err", err_cnt - err0, 1);

    // Test 5: inter-byte timeout after one payload byte
    ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'hAA);
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!frame_err && n < 200);
    check("t5_tmo_latency", n, 51);
    check("t5_term_beat", {29'd0, m_axis_tvalid, m_axis_tlast, m_axis_tuser}, 32'b111);
    check("t5_term_data", {24'd0, m_axis_tdata}, 32'h00);
    check("t5_term_block", {31'd0, s_axis_tready}, 32'd0);
    check("t5_code", {30'd0, err_code}, 32'd2);
    @(posedge aclk); #1;
    idle(2);
    check_beat("t5_b0", 8'hAA, 1'b0, 1'b0);
    check_beat("t5_b1", 8'h00, 1'b1, 1'b1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    idle(3);
    check_beat("t5_b2", 8'h7E, 1'b1, 1'b0);
    check("t5_nbeats", beats.size(), rd);
    check("t5_ok",  ok_cnt - ok0, 1);
    check("t5_err", err_cnt - err0, 1);

    // Test 6a: line error after SOF/LEN, no payload yet
    ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h05);
    rx_err_pulse = 1'b1;
    @(posedge aclk); #1;
    rx_err_pulse = 1'b0;
    idle(3);
    check("t6a_nbeats", beats.size(), rd);
    check("t6a_err", err_cnt - err0, 1);
    check("t6a_code", {30'd0, err_code}, 32'd3);

    // Test 6b: line error coincident with a payload byte: byte dropped, packet terminated
    err0 = err_cnt;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    rx_err_pulse = 1'b1;
    send_byte(8'h22);
    rx_err_pulse = 1'b0;
    idle(3);
    check_beat("t6b_b0", 8'h11, 1'b0, 1'b0);
    check_beat("t6b_b1", 8'h00, 1'b1, 1'b1);
    check("t6b_nbeats", beats.size(), rd);
    check("t6b_err", err_cnt - err0, 1);

    // Test 6c: reset mid-payload with a byte resident in the output register
    m_axis_tready = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    areset = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    check("t6c_rst_m", {29'd0, m_axis_tvalid, m_axis_tlast, m_axis_tuser}, 32'd0);
    check("t6c_rst_pulses", {30'd0, frame_ok, frame_err}, 32'd0);
    check("t6c_rst_code", {30'd0, err_code}, 32'd0);
    check("t6c_rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    m_axis_tready = 1'b1;
    ok0 = ok_cnt; err0 = err_cnt;
    idle(3);
    check("t6c_silent", (ok_cnt - ok0) + (err_cnt - err0), 0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
    idle(3);
    check_beat("t6c_b0", 8'h7E, 1'b1, 1'b0);
    check("t6c_nbeats", beats.size(), rd);
    check("t6c_ok", ok_cnt - ok0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
